wb_write_queue: RTL and testbench

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

---
 rtl/wb_write_queue_if.sv | 36 +++
 rtl/wb_write_queue.sv | 134 +++++++++++++
 tb/tb_wb_write_queue.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wb_write_queue_if.sv
// Bundled pipeline/divide write requests, register-file write port and
// forwarding lookups for wb_write_queue.
interface wb_write_queue_if #(
  parameter int DEPTH = 4
) ();
  logic                     p_we;
  logic [4:0]               p_wa;
  logic [31:0]              p_wd;
  logic                     p_ready;
  logic                     d_valid;
  logic [4:0]               d_wa;
  logic [31:0]              d_wd;
  logic                     d_ready;
  logic                     we3;
  logic [4:0]               wa3;
  logic [31:0]              wd3;
  logic [4:0]               ra1;
  logic [4:0]               ra2;
  logic                     fwd1_hit;
  logic                     fwd2_hit;
  logic [31:0]              fwd1_data;
  logic [31:0]              fwd2_data;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  p_we, p_wa, p_wd, d_valid, d_wa, d_wd, ra1, ra2,
    output p_ready, d_ready, we3, wa3, wd3,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
  );

  modport master (
    output p_we, p_wa, p_wd, d_valid, d_wa, d_wd, ra1, ra2,
    input  p_ready, d_ready, we3, wa3, wd3,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
  );
endinterface

// File: rtl/wb_write_queue.sv
// Register-file writeback queue merging pipeline and divide-unit results,
// draining one write per cycle, with youngest-wins forwarding lookups.
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  wb_write_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            we3_q, we3_d;
  logic [4:0]      wa3_q, wa3_d;
  logic [31:0]     wd3_q, wd3_d;

  logic [AW:0]     free;
  logic            p_ready, d_ready;
  logic            p_push, d_push, pop;
  logic [AW-1:0]   wp;

  logic            hit1, hit2;
  logic [31:0]     data1, data2;
  logic [AW-1:0]   idx;

  // Space comes from the registered count only; a drain this edge does not help.
  assign free    = (AW+1)'(DEPTH) - count_q;
  assign p_ready = (free >= (AW+1)'(1));
  assign d_ready = (free >= (AW+1)'(2)) || ((free >= (AW+1)'(1)) && !bus.p_we);

  // Address 0 requests are accepted but never stored.
  assign d_push = !rst && bus.d_valid && d_ready && (bus.d_wa != 5'd0);
  assign p_push = !rst && bus.p_we && p_ready && (bus.p_wa != 5'd0);
  assign pop    = (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we3_d    = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    wp       = wr_ptr_q;

    if (pop) begin
      we3_d    = 1'b1;
      wa3_d    = mem_q[rd_ptr_q].wa;
      wd3_d    = mem_q[rd_ptr_q].wd;
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_d - (AW+1)'(1);
    end

    // Divide entry goes in first so it is the older of a same-cycle pair.
    if (d_push) begin
      mem_d[wp] = '{wa: bus.d_wa, wd: bus.d_wd};
      wp        = wp + AW'(1);
      count_d   = count_d + (AW+1)'(1);
    end
    if (p_push) begin
      mem_d[wp] = '{wa: bus.p_wa, wd: bus.p_wd};
      wp        = wp + AW'(1);
      count_d   = count_d + (AW+1)'(1);
    end
    wr_ptr_d = wp;
  end

  // Scan oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    hit1  = we3_q && (wa3_q == bus.ra1);
    data1 = wd3_q;
    hit2  = we3_q && (wa3_q == bus.ra2);
    data2 = wd3_q;
    idx   = rd_ptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if ((AW+1)'(i) < count_q) begin
        if (mem_q[idx].wa == bus.ra1) begin
          hit1  = 1'b1;
          data1 = mem_q[idx].wd;
        end
        if (mem_q[idx].wa == bus.ra2) begin
          hit2  = 1'b1;
          data2 = mem_q[idx].wd;
        end
      end
    end
    if (bus.ra1 == 5'd0) hit1 = 1'b0;
    if (bus.ra2 == 5'd0) hit2 = 1'b0;
    if (!hit1) data1 = '0;
    if (!hit2) data2 = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.p_ready   = p_ready;
  assign bus.d_ready   = d_ready;
  assign bus.we3       = we3_q;
  assign bus.wa3       = wa3_q;
  assign bus.wd3       = wd3_q;
  assign bus.fwd1_hit  = hit1;
  assign bus.fwd2_hit  = hit2;
  assign bus.fwd1_data = data1;
  assign bus.fwd2_data = data2;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: stimulus pushes expected register-file
// writes into a scoreboard that a negedge monitor drains and compares.
module tb_wb_write_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [36:0] sb [$];

  wb_write_queue_if #(.DEPTH(4)) bus ();
  wb_write_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst && bus.we3) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got wa=%0d wd=%0h expected no write", bus.wa3, bus.wd3);
      end else begin
        e = sb.pop_front();
        chk("rf_write", {27'b0, bus.wa3, bus.wd3}, {27'b0, e});
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.p_we = 1'b0; bus.p_wa = '0; bus.p_wd = '0;
    bus.d_valid = 1'b0; bus.d_wa = '0; bus.d_wd = '0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && (bus.count != 0 || sb.size() != 0); k++) cycle();
    chk(name, 64'(sb.size()), 64'd0);
    chk({name, "_count"}, 64'(bus.count), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.ra1 = '0; bus.ra2 = '0;
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_we3", 64'(bus.we3), 64'd0);
    chk("rst_wa3", 64'(bus.wa3), 64'd0);
    chk("rst_wd3", 64'(bus.wd3), 64'd0);
    chk("rst_ready", {62'b0, bus.p_ready, bus.d_ready}, 64'd3);

    // Single pipeline write: one cycle of latency through the queue.
    bus.p_we = 1'b1; bus.p_wa = 5'd5; bus.p_wd = 32'h11;
    sb.push_back({5'd5, 32'h11});
    cycle(); idle();
    chk("single_count", 64'(bus.count), 64'd1);
    bus.ra1 = 5'd5;
    #1 chk("single_fwd_q", {31'b0, bus.fwd1_hit, bus.fwd1_data}, {31'b0, 1'b1, 32'h11});
    cycle();
    chk("single_we3", 64'(bus.we3), 64'd1);
    chk("single_fwd_out", {31'b0, bus.fwd1_hit, bus.fwd1_data}, {31'b0, 1'b1, 32'h11});
    cycle();
    chk("single_we3_off", 64'(bus.we3), 64'd0);
    chk("single_hold", {27'b0, bus.wa3, bus.wd3}, {27'b0, 5'd5, 32'h11});

    // Same-cycle divide + pipeline to r7: divide first, pipeline is youngest.
    bus.d_valid = 1'b1; bus.d_wa = 5'd7; bus.d_wd = 32'hAA;
    bus.p_we = 1'b1; bus.p_wa = 5'd7; bus.p_wd = 32'hBB;
    sb.push_back({5'd7, 32'hAA});
    sb.push_back({5'd7, 32'hBB});
    cycle(); idle();
    bus.ra1 = 5'd7; bus.ra2 = 5'd5;
    #1;
    chk("dual_count", 64'(bus.count), 64'd2);
    chk("dual_fwd1", {31'b0, bus.fwd1_hit, bus.fwd1_data}, {31'b0, 1'b1, 32'hBB});
    chk("dual_fwd2_miss", {31'b0, bus.fwd2_hit, bus.fwd2_data}, 64'd0);
    cycle();
    chk("dual_fwd1_mid", {31'b0, bus.fwd1_hit, bus.fwd1_data}, {31'b0, 1'b1, 32'hBB});
    cycle();
    chk("dual_fwd1_out", {31'b0, bus.fwd1_hit, bus.fwd1_data}, {31'b0, 1'b1, 32'hBB});
    cycle();
    chk("dual_fwd1_gone", 64'(bus.fwd1_hit), 64'd0);

    // Address 0 is swallowed.
    bus.p_we = 1'b1; bus.p_wa = 5'd0; bus.p_wd = 32'hFF;
    cycle(); idle();
    bus.ra1 = 5'd0;
    #1;
    chk("r0_count", 64'(bus.count), 64'd0);
    chk("r0_fwd", 64'(bus.fwd1_hit), 64'd0);
    cycle();
    chk("r0_we3", 64'(bus.we3), 64'd0);

    // Fill under back-pressure.
    bus.d_valid = 1'b1; bus.d_wa = 5'd10; bus.d_wd = 32'h100;
    bus.p_we = 1'b1; bus.p_wa = 5'd11; bus.p_wd = 32'h101;
    sb.push_back({5'd10, 32'h100}); sb.push_back({5'd11, 32'h101});
    cycle();
    chk("fill_count2", 64'(bus.count), 64'd2);
    bus.d_wa = 5'd12; bus.d_wd = 32'h102;
    bus.p_wa = 5'd13; bus.p_wd = 32'h103;
    sb.push_back({5'd12, 32'h102}); sb.push_back({5'd13, 32'h103});
    cycle();
    bus.d_wa = 5'd15; bus.d_wd = 32'h105;
    bus.p_wa = 5'd14; bus.p_wd = 32'h104;
    #1;
    chk("fill_count3", 64'(bus.count), 64'd3);
    chk("fill_p_ready3", 64'(bus.p_ready), 64'd1);
    chk("fill_d_ready3_pwe", 64'(bus.d_ready), 64'd0);
    sb.push_back({5'd14, 32'h104});
    cycle();
    bus.p_we = 1'b0;
    #1;
    chk("fill_count3b", 64'(bus.count), 64'd3);
    chk("fill_d_ready3_nopwe", 64'(bus.d_ready), 64'd1);
    sb.push_back({5'd15, 32'h105});
    cycle(); idle();
    drain("fill_drain");

    // Reset mid-drain discards everything; requests during reset are dropped.
    bus.d_valid = 1'b1; bus.d_wa = 5'd20; bus.d_wd = 32'h20;
    bus.p_we = 1'b1; bus.p_wa = 5'd3; bus.p_wd = 32'h1;
    sb.push_back({5'd20, 32'h20});
    cycle();
    bus.d_wa = 5'd4; bus.d_wd = 32'h2;
    bus.p_wa = 5'd3; bus.p_wd = 32'h3;
    cycle(); idle();
    bus.ra1 = 5'd3; bus.ra2 = 5'd4;
    #1;
    chk("pre_rst_count", 64'(bus.count), 64'd3);
    chk("pre_rst_fwd1", {31'b0, bus.fwd1_hit, bus.fwd1_data}, {31'b0, 1'b1, 32'h3});
    chk("pre_rst_fwd2", {31'b0, bus.fwd2_hit, bus.fwd2_data}, {31'b0, 1'b1, 32'h2});
    rst = 1'b1;
    bus.p_we = 1'b1; bus.p_wa = 5'd8; bus.p_wd = 32'h8;
    cycle();
    rst = 1'b0; idle();
    sb.delete();
    #1;
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_we3", 64'(bus.we3), 64'd0);
    chk("mid_rst_out", {27'b0, bus.wa3, bus.wd3}, 64'd0);
    chk("mid_rst_fwd", {62'b0, bus.fwd1_hit, bus.fwd2_hit}, 64'd0);
    cycle();
    chk("post_rst_we3", 64'(bus.we3), 64'd0);

    // Streaming pipeline writes, wrapping the address through r0.
    for (int i = 0; i < 20; i++) begin
      logic [4:0] a;
      a = 5'(25 + i);
      bus.p_we = 1'b1; bus.p_wa = a; bus.p_wd = 32'h1000 + 32'(i);
      if (a != 5'd0) sb.push_back({a, 32'h1000 + 32'(i)});
      cycle();
      chk("stream_count", 64'(bus.count <= 1), 64'd1);
    end
    idle();
    drain("stream_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
